// File: rtl/carrd_writeback_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carrd_wb_pkg
// Purpose  : Shared types and constants for the Carrd writeback arbiter:
//            destination encoding, writeback entry layout, channel indices.
// Revision : 1.0  initial release
// ============================================================================
package carrd_wb_pkg;

  localparam int WB_NUM_CH     = 5;
  localparam int WB_LANES      = 4;
  localparam int WB_LANE_W     = 128;
  localparam int WB_ADDR_W     = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_DATA_W     = WB_LANES * WB_LANE_W;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_V    = 2'd1,
    DEST_X    = 2'd2,
    DEST_EL   = 2'd3
  } dest_e;

  typedef struct packed {
    dest_e                  dest;
    logic [WB_ADDR_W-1:0]   addr;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

  localparam int CH_VALU  = 0;
  localparam int CH_VMUL  = 1;
  localparam int CH_VLSU  = 2;
  localparam int CH_VSLDU = 3;
  localparam int CH_VRED  = 4;

  // Increment modulo n, used to advance the round-robin start position.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/carrd_writeback_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : carrd_writeback_arb_if
// Purpose  : Channel handshake and register-file write bus of the writeback
//            arbiter.
//   master : drives ch_valid/ch_sel_dest/ch_addr/ch_data/wb_stall,
//            observes ch_ready and the register-file write outputs
//   slave  : the arbiter side (opposite directions)
// Revision : 1.0  initial release
// ============================================================================
interface carrd_writeback_arb_if #(
  parameter int NUM_CH = 5,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 512,
  parameter int CH_W   = 3
);
  logic [NUM_CH-1:0]             ch_valid;
  logic [NUM_CH-1:0]             ch_ready;
  logic [NUM_CH-1:0][1:0]        ch_sel_dest;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic                          wb_stall;
  logic                          v_reg_wr_en;
  logic                          x_reg_wr_en;
  logic                          el_wr_en;
  logic [ADDR_W-1:0]             reg_wr_addr;
  logic [DATA_W-1:0]             reg_wr_data;
  logic [CH_W-1:0]               wb_ch;

  modport master (
    output ch_valid, ch_sel_dest, ch_addr, ch_data, wb_stall,
    input  ch_ready, v_reg_wr_en, x_reg_wr_en, el_wr_en,
           reg_wr_addr, reg_wr_data, wb_ch
  );

  modport slave (
    input  ch_valid, ch_sel_dest, ch_addr, ch_data, wb_stall,
    output ch_ready, v_reg_wr_en, x_reg_wr_en, el_wr_en,
           reg_wr_addr, reg_wr_data, wb_ch
  );
endinterface
`default_nettype wire

// File: rtl/carrd_writeback_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : carrd_wb_fifo
// Purpose  : Per-channel synchronous result FIFO, power-of-two depth.
//   clk, nrst   clock / asynchronous active-low reset
//   i_push      write request (ignored while full)
//   i_data      entry to write
//   i_pop       read request (ignored while empty)
//   o_data      head entry
//   o_full      registered-state full flag
//   o_empty     registered-state empty flag
// Revision : 1.0  initial release
// ============================================================================
module carrd_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             nrst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Full is decided from the count register alone, so a full FIFO refuses
  // a push even in a cycle where it is also popped.
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/carrd_writeback_arb.sv
`default_nettype none
// ============================================================================
// Module   : carrd_writeback_arb
// Purpose  : Writeback stage of the Carrd vector coprocessor. Merges NUM_CH
//            functional-unit result channels into one register-file write
//            port through per-channel FIFOs, an arbiter and a registered
//            destination decode.
//   clk, nrst  clock / asynchronous active-low reset
//   bus        carrd_writeback_arb_if.slave: channel valid/ready, sel_dest,
//              addr, data, wb_stall in; write strobes, addr, data, wb_ch out
// Config   : CARRD_WB_RR_EN defined   -> round-robin arbitration
//            CARRD_WB_RR_EN undefined -> fixed priority, lowest index wins
// Revision : 1.0  initial release
// ============================================================================
module carrd_writeback_arb
  import carrd_wb_pkg::*;
#(
  parameter int NUM_CH     = WB_NUM_CH,
  parameter int LANES      = WB_LANES,
  parameter int LANE_W     = WB_LANE_W,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int ADDR_W     = WB_ADDR_W
) (
  input  wire logic clk,
  input  wire logic nrst,
  carrd_writeback_arb_if.slave bus
);
  localparam int DATA_W = LANES * LANE_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W  = 2 + ADDR_W + DATA_W;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_pop;
  logic [ENT_W-1:0]  w_head [NUM_CH];

  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt;
  logic [ENT_W-1:0]  w_ent;
  dest_e             w_dest;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_v_en;
  logic              r_x_en;
  logic              r_el_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_ch;

  // --------------------------------------------------------------------------
  // Per-channel result FIFOs; entry = {sel_dest, addr, data}
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      carrd_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (bus.ch_valid[i]),
        .i_data  ({bus.ch_sel_dest[i], bus.ch_addr[i], bus.ch_data[i]}),
        .i_pop   (w_pop[i]),
        .o_data  (w_head[i]),
        .o_full  (w_full[i]),
        .o_empty (w_empty[i])
      );
    end
  endgenerate

  assign bus.ch_ready = ~w_full;

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
`ifdef CARRD_WB_RR_EN
  // r_ptr is the first channel searched; it moves past the winner on a grant.
  logic [CH_W-1:0] r_ptr;

  always_comb begin
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(r_ptr) + i) % NUM_CH;
      if (!w_gnt_vld && !w_empty[idx] && !bus.wb_stall) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= CH_W'(wrap_inc(int'(w_gnt), NUM_CH));
    end
  end
`else
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    // Descending scan so the lowest requesting index is the last to assign.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!w_empty[i] && !bus.wb_stall) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_pop = '0;
    if (w_gnt_vld) w_pop[w_gnt] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Destination decode and output register
  // --------------------------------------------------------------------------
  assign w_ent  = w_head[w_gnt];
  assign w_dest = dest_e'(w_ent[ENT_W-1 -: 2]);
  assign w_addr = w_ent[DATA_W +: ADDR_W];
  assign w_data = w_ent[DATA_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_v_en  <= 1'b0;
      r_x_en  <= 1'b0;
      r_el_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ch    <= '0;
    end else begin
      r_v_en  <= 1'b0;
      r_x_en  <= 1'b0;
      r_el_en <= 1'b0;
      // DEST_NONE entries are dequeued but leave the write bus untouched.
      if (w_gnt_vld && (w_dest != DEST_NONE)) begin
        r_addr <= w_addr;
        r_ch   <= w_gnt;
        case (w_dest)
          DEST_V: begin
            r_v_en <= 1'b1;
            r_data <= w_data;
          end
          DEST_X: begin
            r_x_en <= 1'b1;
            r_data <= DATA_W'(w_data[31:0]);
          end
          DEST_EL: begin
            r_el_en <= 1'b1;
            r_data  <= DATA_W'(w_data[31:0]);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.v_reg_wr_en = r_v_en;
  assign bus.x_reg_wr_en = r_x_en;
  assign bus.el_wr_en    = r_el_en;
  assign bus.reg_wr_addr = r_addr;
  assign bus.reg_wr_data = r_data;
  assign bus.wb_ch       = r_ch;

endmodule
`default_nettype wire
